// File: rtl/bcd_time_counter_pkg.sv
// Shared BCD types, limits and load-range helpers for the time-of-day counter.
package time_pkg;
   typedef logic [3:0] bcd_digit_t;
   typedef logic [7:0] bcd_pair_t;

   localparam bcd_pair_t SEC_MAX = 8'h59;
   localparam bcd_pair_t MIN_MAX = 8'h59;

   function automatic bcd_pair_t to_bcd_pair(input int unsigned v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   // With both nibbles at most 9, packed BCD orders like its decimal value.
   function automatic logic bcd_pair_valid(input bcd_pair_t value, input bcd_pair_t max_pair);
      return (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) && (value <= max_pair);
   endfunction
endpackage

// File: rtl/bcd_time_counter_if.sv
// Data/strobe bundle between the time counter and its user (load side and display side).
interface bcd_time_counter_if;
   import time_pkg::*;

   logic      iClk1s;
   logic      iRun;
   logic      iLoad;
   bcd_pair_t iLoadH;
   bcd_pair_t iLoadM;
   bcd_pair_t iLoadS;
   bcd_pair_t oHour;
   bcd_pair_t oMin;
   bcd_pair_t oSec;
   logic      oTick;
   logic      oDayWrap;
   logic      oLoadErr;

   modport slave (
      input  iClk1s, iRun, iLoad, iLoadH, iLoadM, iLoadS,
      output oHour, oMin, oSec, oTick, oDayWrap, oLoadErr
   );

   modport master (
      output iClk1s, iRun, iLoad, iLoadH, iLoadM, iLoadS,
      input  oHour, oMin, oSec, oTick, oDayWrap, oLoadErr
   );
endinterface

// File: rtl/bcd_time_counter_bcd2.sv
// Two-digit packed-BCD modulo counter with synchronous load and combinational carry-out.
module bcd2_counter
   import time_pkg::*;
(
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      inc_i,
   input  logic      load_i,
   input  bcd_pair_t load_val_i,
   input  bcd_pair_t max_i,
   output bcd_pair_t val_o,
   output logic      carry_o
);
   bcd_pair_t val_q, val_d;
   logic      at_max;

   assign at_max  = (val_q == max_i);
   assign carry_o = inc_i && at_max;
   assign val_o   = val_q;

   always_comb begin
      val_d = val_q;
      if (load_i) begin
         val_d = load_val_i;
      end else if (inc_i) begin
         if (at_max) begin
            val_d = '0;
         end else if (val_q[3:0] == 4'd9) begin
            val_d = {val_q[7:4] + 4'd1, 4'd0};
         end else begin
            val_d = {val_q[7:4], val_q[3:0] + 4'd1};
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) val_q <= '0;
      else         val_q <= val_d;
   end
endmodule

// File: rtl/bcd_time_counter.sv
// HH:MM:SS packed-BCD time-of-day counter stepped by rising edges of a slow square wave,
// with a range-checked load port.
module bcd_time_counter
   import time_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned HOUR_MAX    = 23
) (
   input  logic               iClock50M,
   input  logic               iRSt_n,
   bcd_time_counter_if.slave  bus
);
   localparam bcd_pair_t HOUR_MAX_BCD = to_bcd_pair(HOUR_MAX);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   prime_q;
   logic                   tick_q, dwrap_q, err_q;
   logic                   rise, load_ok, ld_en, step;
   logic                   sec_c, min_c, hour_c;
   bcd_pair_t              sec_v, min_v, hour_v;

   assign rise    = prime_q && sync_q[SYNC_STAGES-1] && !prev_q;
   assign load_ok = bcd_pair_valid(bus.iLoadS, SEC_MAX) &&
                    bcd_pair_valid(bus.iLoadM, MIN_MAX) &&
                    bcd_pair_valid(bus.iLoadH, HOUR_MAX_BCD);
   assign ld_en   = bus.iLoad && load_ok;
   // A load in the same cycle as a rise consumes that second, valid or not.
   assign step    = rise && bus.iRun && !bus.iLoad;

   // Until primed, the chain and edge register are seeded with the current level,
   // so an input already high at reset release never looks like a rise.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], bus.iClk1s};
      prev_d = sync_q[SYNC_STAGES-1];
      if (!prime_q) begin
         sync_d = {SYNC_STAGES{bus.iClk1s}};
         prev_d = bus.iClk1s;
      end
   end

   always_ff @(posedge iClock50M or negedge iRSt_n) begin
      if (!iRSt_n) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         prime_q <= 1'b0;
         tick_q  <= 1'b0;
         dwrap_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         prime_q <= 1'b1;
         tick_q  <= step;
         dwrap_q <= hour_c;
         err_q   <= bus.iLoad && !load_ok;
      end
   end

   bcd2_counter u_sec (
      .clk_i(iClock50M), .rst_ni(iRSt_n), .inc_i(step), .load_i(ld_en),
      .load_val_i(bus.iLoadS), .max_i(SEC_MAX), .val_o(sec_v), .carry_o(sec_c)
   );

   bcd2_counter u_min (
      .clk_i(iClock50M), .rst_ni(iRSt_n), .inc_i(sec_c), .load_i(ld_en),
      .load_val_i(bus.iLoadM), .max_i(MIN_MAX), .val_o(min_v), .carry_o(min_c)
   );

   bcd2_counter u_hour (
      .clk_i(iClock50M), .rst_ni(iRSt_n), .inc_i(min_c), .load_i(ld_en),
      .load_val_i(bus.iLoadH), .max_i(HOUR_MAX_BCD), .val_o(hour_v), .carry_o(hour_c)
   );

   assign bus.oSec     = sec_v;
   assign bus.oMin     = min_v;
   assign bus.oHour    = hour_v;
   assign bus.oTick    = tick_q;
   assign bus.oDayWrap = dwrap_q;
   assign bus.oLoadErr = err_q;
endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench for bcd_time_counter: 24-hour and 12-hour instances on one clock.
`timescale 1ns/1ps
module tb_bcd_time_counter;
   import time_pkg::*;

   typedef struct packed {
      logic       tick;
      logic       dw;
      logic       err;
      logic [7:0] h;
      logic [7:0] m;
      logic [7:0] s;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bcd_time_counter_if b23();
   bcd_time_counter_if b11();

   bcd_time_counter #(.SYNC_STAGES(2), .HOUR_MAX(23)) dut23 (
      .iClock50M(clk), .iRSt_n(rst_n), .bus(b23)
   );
   bcd_time_counter #(.SYNC_STAGES(2), .HOUR_MAX(11)) dut11 (
      .iClock50M(clk), .iRSt_n(rst_n), .bus(b11)
   );

   exp_t q23[$];
   exp_t q11[$];
   exp_t got23, exp23, got11, exp11;
   int tests = 0;
   int fails = 0;

   // Monitors: every output event must match the next queued expectation.
   always @(negedge clk) begin
      if (b23.oTick || b23.oDayWrap || b23.oLoadErr) begin
         got23 = {b23.oTick, b23.oDayWrap, b23.oLoadErr, b23.oHour, b23.oMin, b23.oSec};
         tests++;
         if (q23.size() == 0) begin
            fails++;
            $display("FAIL ev23_unexpected got tick/dw/err=%b%b%b %h:%h:%h required no event",
                     got23.tick, got23.dw, got23.err, got23.h, got23.m, got23.s);
         end else begin
            exp23 = q23.pop_front();
            if (got23 !== exp23) begin
               fails++;
               $display("FAIL ev23 got tick/dw/err=%b%b%b %h:%h:%h required %b%b%b %h:%h:%h",
                        got23.tick, got23.dw, got23.err, got23.h, got23.m, got23.s,
                        exp23.tick, exp23.dw, exp23.err, exp23.h, exp23.m, exp23.s);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (b11.oTick || b11.oDayWrap || b11.oLoadErr) begin
         got11 = {b11.oTick, b11.oDayWrap, b11.oLoadErr, b11.oHour, b11.oMin, b11.oSec};
         tests++;
         if (q11.size() == 0) begin
            fails++;
            $display("FAIL ev11_unexpected got tick/dw/err=%b%b%b %h:%h:%h required no event",
                     got11.tick, got11.dw, got11.err, got11.h, got11.m, got11.s);
         end else begin
            exp11 = q11.pop_front();
            if (got11 !== exp11) begin
               fails++;
               $display("FAIL ev11 got tick/dw/err=%b%b%b %h:%h:%h required %b%b%b %h:%h:%h",
                        got11.tick, got11.dw, got11.err, got11.h, got11.m, got11.s,
                        exp11.tick, exp11.dw, exp11.err, exp11.h, exp11.m, exp11.s);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_c1(input bit sel, input logic v);
      if (sel) b11.iClk1s = v;
      else     b23.iClk1s = v;
   endtask

   task automatic pulse1s(input bit sel);
      set_c1(sel, 1'b1);
      step(4);
      set_c1(sel, 1'b0);
      step(4);
   endtask

   task automatic push(input bit sel, input logic dw, input logic err,
                       input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      exp_t e;
      e = {~err, dw, err, h, m, s};
      if (sel) q11.push_back(e);
      else     q23.push_back(e);
   endtask

   task automatic load(input bit sel, input logic [7:0] h, input logic [7:0] m,
                       input logic [7:0] s);
      if (sel) begin
         b11.iLoadH = h; b11.iLoadM = m; b11.iLoadS = s; b11.iLoad = 1'b1;
      end else begin
         b23.iLoadH = h; b23.iLoadM = m; b23.iLoadS = s; b23.iLoad = 1'b1;
      end
      step(1);
      b11.iLoad = 1'b0;
      b23.iLoad = 1'b0;
   endtask

   task automatic chk_time(input bit sel, input string name, input logic [7:0] h,
                           input logic [7:0] m, input logic [7:0] s);
      logic [23:0] got;
      logic [2:0]  pulses;
      got    = sel ? {b11.oHour, b11.oMin, b11.oSec} : {b23.oHour, b23.oMin, b23.oSec};
      pulses = sel ? {b11.oTick, b11.oDayWrap, b11.oLoadErr}
                   : {b23.oTick, b23.oDayWrap, b23.oLoadErr};
      tests++;
      if (got !== {h, m, s} || pulses !== 3'b000) begin
         fails++;
         $display("FAIL %s got %h pulses=%b required %h%h%h pulses=000", name, got, pulses, h, m, s);
      end
   endtask

   initial begin
      b23.iClk1s = 1'b1; b23.iRun = 1'b1; b23.iLoad = 1'b0;
      b23.iLoadH = '0;   b23.iLoadM = '0; b23.iLoadS = '0;
      b11.iClk1s = 1'b0; b11.iRun = 1'b1; b11.iLoad = 1'b0;
      b11.iLoadH = '0;   b11.iLoadM = '0; b11.iLoadS = '0;

      step(3);
      chk_time(0, "reset_state", 8'h00, 8'h00, 8'h00);
      rst_n = 1'b1;
      step(6);
      chk_time(0, "high_at_release", 8'h00, 8'h00, 8'h00);
      set_c1(0, 1'b0);
      step(4);

      for (int i = 1; i <= 5; i++) begin
         push(0, 1'b0, 1'b0, 8'h00, 8'h00, 8'(i));
         pulse1s(0);
      end
      chk_time(0, "five_ticks", 8'h00, 8'h00, 8'h05);

      load(0, 8'h23, 8'h59, 8'h58);
      chk_time(0, "load_valid", 8'h23, 8'h59, 8'h58);
      push(0, 1'b0, 1'b0, 8'h23, 8'h59, 8'h59);
      pulse1s(0);
      push(0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      pulse1s(0);

      push(0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
      load(0, 8'h12, 8'h60, 8'h00);
      step(2);
      push(0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
      load(0, 8'h12, 8'h59, 8'h0A);
      step(2);
      chk_time(0, "invalid_load_keeps", 8'h00, 8'h00, 8'h00);

      set_c1(0, 1'b1);
      step(2);
      load(0, 8'h08, 8'h30, 8'h00);
      step(2);
      set_c1(0, 1'b0);
      step(4);
      chk_time(0, "load_beats_rise", 8'h08, 8'h30, 8'h00);
      push(0, 1'b0, 1'b0, 8'h08, 8'h30, 8'h01);
      pulse1s(0);

      b23.iRun = 1'b0;
      repeat (3) pulse1s(0);
      b23.iRun = 1'b1;
      push(0, 1'b0, 1'b0, 8'h08, 8'h30, 8'h02);
      pulse1s(0);
      chk_time(0, "hold_then_run", 8'h08, 8'h30, 8'h02);

      #2;
      rst_n = 1'b0;
      #1;
      chk_time(0, "async_reset", 8'h00, 8'h00, 8'h00);
      step(2);
      rst_n = 1'b1;
      step(3);
      push(0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01);
      pulse1s(0);

      load(1, 8'h11, 8'h59, 8'h59);
      chk_time(1, "h11_load", 8'h11, 8'h59, 8'h59);
      push(1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      pulse1s(1);
      push(1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
      load(1, 8'h12, 8'h00, 8'h00);
      step(2);
      chk_time(1, "h11_reject_keeps", 8'h00, 8'h00, 8'h00);

      step(10);
      tests++;
      if (q23.size() != 0) begin
         fails++;
         $display("FAIL ev23_missing got %0d events outstanding required 0", q23.size());
      end
      tests++;
      if (q11.size() != 0) begin
         fails++;
         $display("FAIL ev11_missing got %0d events outstanding required 0", q11.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
